// File: rtl/spi_codec_target.sv
// Mode-0 SPI target oversampled on the system clock.
// Shifts a word in on mosi while returning the held sample on miso.
module spi_codec_target #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oeb,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_we,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             tx_underrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_d, r_cs_d;
   logic [WIDTH-1:0]       r_hold, r_tx, r_rx, r_rx_data;
   logic [CW-1:0]          r_cnt;
   logic                   r_fresh, r_ovr;
   logic                   r_miso, r_oeb;
   logic                   r_rx_valid, r_frame_err, r_tx_underrun;

   logic w_sclk_s, w_cs_s, w_mosi_s;
   logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic w_start, w_rx_shift, w_fin, w_abort;
   logic w_tx_shift, w_ovr, w_to_idle;

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;
   assign w_cs_fall   = ~w_cs_s & r_cs_d;

   // cs idles high so the chain resets to ones; no spurious edge after reset
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= w_sclk_s;
         r_cs_d      <= w_cs_s;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_rx_shift = 1'b0;
      w_fin      = 1'b0;
      w_abort    = 1'b0;
      w_tx_shift = 1'b0;
      w_ovr      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_cs_fall) begin
               w_start = 1'b1;
               w_next  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_sclk_rise) begin
               w_rx_shift = 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  w_fin  = 1'b1;
                  w_next = S_DONE;
               end
            end
            if (w_sclk_fall && r_cnt < CW'(WIDTH))
               w_tx_shift = 1'b1;
            // a final bit landing with cs rise still completes the frame
            if (w_cs_rise) begin
               w_abort = ~w_fin;
               w_next  = S_IDLE;
            end
         end
         S_DONE: begin
            if (w_sclk_rise && !r_ovr)
               w_ovr = 1'b1;
            if (w_cs_rise)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      w_to_idle = (r_state != S_IDLE) && (w_next == S_IDLE);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_hold        <= '0;
         r_fresh       <= 1'b0;
         r_tx          <= '0;
         r_rx          <= '0;
         r_rx_data     <= '0;
         r_cnt         <= '0;
         r_ovr         <= 1'b0;
         r_miso        <= 1'b0;
         r_oeb         <= 1'b1;
         r_rx_valid    <= 1'b0;
         r_frame_err   <= 1'b0;
         r_tx_underrun <= 1'b0;
      end else begin
         r_rx_valid    <= w_fin;
         r_frame_err   <= w_abort | w_ovr;
         r_tx_underrun <= w_start & ~r_fresh;
         if (tx_we) begin
            r_hold  <= tx_data;
            r_fresh <= 1'b1;
         end else if (w_start) begin
            r_fresh <= 1'b0;
         end
         if (w_start) begin
            r_tx   <= r_hold;
            r_miso <= r_hold[WIDTH-1];
            r_oeb  <= 1'b0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
         end
         if (w_rx_shift) begin
            r_rx  <= {r_rx[WIDTH-2:0], w_mosi_s};
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_fin) begin
            r_rx_data <= {r_rx[WIDTH-2:0], w_mosi_s};
            r_miso    <= 1'b0;
         end else if (w_tx_shift) begin
            r_tx   <= r_tx << 1;
            r_miso <= r_tx[WIDTH-2];
         end
         if (w_ovr)
            r_ovr <= 1'b1;
         if (w_to_idle) begin
            r_oeb  <= 1'b1;
            r_miso <= 1'b0;
         end
      end
   end

   assign miso        = r_miso;
   assign miso_oeb    = r_oeb;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign frame_err   = r_frame_err;
   assign tx_underrun = r_tx_underrun;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_codec_target.sv
// Bench for spi_codec_target: table of frames plus a mid-frame reset.
// Received words go through an expected/observed scoreboard.
module tb_spi_codec_target;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk, cs, mosi;
   logic        miso, miso_oeb;
   logic [15:0] tx_data;
   logic        tx_we;
   logic [15:0] rx_data;
   logic        rx_valid, frame_err, tx_underrun, busy;

   spi_codec_target #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .sclk        (sclk),
      .cs          (cs),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oeb    (miso_oeb),
      .tx_data     (tx_data),
      .tx_we       (tx_we),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .tx_underrun (tx_underrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] tx;
      logic        mid;
      logic [15:0] mid_tx;
      logic [15:0] mosi;
      int          nbits;
      logic [15:0] exp_miso;
      int          rv;
      int          fe;
      int          ur;
      logic [15:0] exp_rx;
   } vec_t;

   vec_t        vecs[8];
   int          total = 0;
   int          bad = 0;
   int          rv_cnt = 0, fe_cnt = 0, ur_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] obs_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            rv_cnt++;
            obs_q.push_back(rx_data);
         end
         if (frame_err)   fe_cnt++;
         if (tx_underrun) ur_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_hold(input logic [15:0] d);
      tx_data = d;
      tx_we   = 1'b1;
      clks(1);
      tx_we   = 1'b0;
   endtask

   task automatic drain(input string nm);
      logic [15:0] o;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         if (exp_q.size() == 0) chk({nm, " extra rx"}, 32'(o), 32'hFFFF_FFFF);
         else                   chk({nm, " rx word"}, 32'(o), 32'(exp_q.pop_front()));
      end
      while (exp_q.size() > 0) begin
         chk({nm, " missing rx"}, 32'h0, 32'(exp_q.pop_front()));
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic [31:0] cap, want;
      int          rv0, fe0, ur0;
      bit          oeb_ok;
      rv0 = rv_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
      cap = '0;
      oeb_ok = 1'b1;
      if (v.we) begin
         write_hold(v.tx);
         clks(2);
      end
      if (v.rv == 1) exp_q.push_back(v.exp_rx);
      cs = 1'b0;
      for (int i = 0; i < v.nbits; i++) begin
         mosi = (i < 16) ? v.mosi[15-i] : 1'b0;
         clks(4);
         cap = {cap[30:0], miso};
         if (miso_oeb !== 1'b0) oeb_ok = 1'b0;
         sclk = 1'b1;
         if (v.mid && i == 8) begin
            write_hold(v.mid_tx);
            clks(3);
         end else begin
            clks(4);
         end
         sclk = 1'b0;
      end
      clks(8);
      cs = 1'b1;
      clks(6);
      if (v.nbits <= 16) want = 32'(v.exp_miso) >> (16 - v.nbits);
      else               want = 32'(v.exp_miso) << (v.nbits - 16);
      chk({nm, " miso bits"}, cap, want);
      chk({nm, " oeb low in frame"}, 32'(oeb_ok), 32'd1);
      chk({nm, " oeb after"}, 32'(miso_oeb), 32'd1);
      chk({nm, " busy after"}, 32'(busy), 32'd0);
      chk({nm, " rx_valid count"}, 32'(rv_cnt - rv0), 32'(v.rv));
      chk({nm, " frame_err count"}, 32'(fe_cnt - fe0), 32'(v.fe));
      chk({nm, " underrun count"}, 32'(ur_cnt - ur0), 32'(v.ur));
      chk({nm, " rx_data"}, 32'(rx_data), 32'(v.exp_rx));
      drain(nm);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, " miso"}, 32'(miso), 32'd0);
      chk({nm, " miso_oeb"}, 32'(miso_oeb), 32'd1);
      chk({nm, " rx_data"}, 32'(rx_data), 32'd0);
      chk({nm, " rx_valid"}, 32'(rx_valid), 32'd0);
      chk({nm, " frame_err"}, 32'(frame_err), 32'd0);
      chk({nm, " tx_underrun"}, 32'(tx_underrun), 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int rv0, fe0;
      //          we  tx       mid mid_tx   mosi     n   miso     rv fe ur rx
      vecs[0] = '{1, 16'hA5C3, 0, 16'h0000, 16'h1234, 16, 16'hA5C3, 1, 0, 0, 16'h1234};
      vecs[1] = '{0, 16'h0000, 0, 16'h0000, 16'h0F0F,  9, 16'hA5C3, 0, 1, 1, 16'h1234};
      vecs[2] = '{1, 16'h00FF, 0, 16'h0000, 16'hFFFF, 16, 16'h00FF, 1, 0, 0, 16'hFFFF};
      vecs[3] = '{0, 16'h0000, 0, 16'h0000, 16'h0001, 16, 16'h00FF, 1, 0, 1, 16'h0001};
      vecs[4] = '{1, 16'h3C3C, 0, 16'h0000, 16'h8001, 18, 16'h3C3C, 1, 1, 0, 16'h8001};
      vecs[5] = '{1, 16'hAAAA, 1, 16'h5555, 16'h5A5A, 16, 16'hAAAA, 1, 0, 0, 16'h5A5A};
      vecs[6] = '{0, 16'h0000, 0, 16'h0000, 16'hC3C3, 16, 16'h5555, 1, 0, 0, 16'hC3C3};
      vecs[7] = '{0, 16'h0000, 0, 16'h0000, 16'hABCD, 16, 16'h0000, 1, 0, 1, 16'hABCD};

      rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
      tx_data = '0; tx_we = 1'b0;
      clks(3);
      check_reset_vals("reset");
      rst = 1'b0;
      clks(4);

      for (int k = 0; k < 7; k++)
         run_vec(vecs[k], $sformatf("vec%0d", k));

      // reset in the middle of a frame
      rv0 = rv_cnt; fe0 = fe_cnt;
      write_hold(16'h1111);
      clks(2);
      cs = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mosi = i[0];
         clks(4);
         sclk = 1'b1;
         clks(4);
         if (i < 4) sclk = 1'b0;
      end
      chk("midrst busy before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      sclk = 1'b0; cs = 1'b1;
      clks(4);
      rst = 1'b0;
      clks(6);
      chk("midrst rx_valid count", 32'(rv_cnt - rv0), 32'd0);
      chk("midrst frame_err count", 32'(fe_cnt - fe0), 32'd0);
      chk("midrst busy after", 32'(busy), 32'd0);

      run_vec(vecs[7], "post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_codec_target.md
# spi_codec_target

SPI target (responder) for the pedal's 16-bit SPI sample link, oversampled on the system clock. It answers the master side of the link: it shifts a 16-bit word in on `mosi` (the DAC word) and shifts the current 16-bit sample out on `miso` (the ADC word). It is the on-chip loopback and test responder for the SPI controller, and doubles as the receive end when an external master drives the pedal's GPIO pins. SPI mode 0 only: idle `sclk` low, sample on rising edge, shift on falling edge, MSB first.

## Interface
- `WIDTH`, 16: bits per frame.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `mosi` and `cs`; minimum 2.

- `wb_clk_i`  in  1  system clock; all logic on its rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `sclk`  in  1  SPI clock from the master; asynchronous to `wb_clk_i`.
- `cs`  in  1  chip select, active-low; asynchronous.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `miso_oeb`  out  1  pad output-enable-bar; 0 drives `miso`.
- `tx_data`  in  WIDTH  next sample to transmit.
- `tx_we`  in  1  one-cycle strobe that writes `tx_data` into the holding register.
- `rx_data`  out  WIDTH  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted or overrun.
- `tx_underrun`  out  1  one-cycle pulse when a frame starts without a fresh `tx_we`.
- `busy`  out  1  high while a frame is in progress (SHIFT or DONE).

## Operation
- **Inputs:** `sclk`, `cs` and `mosi` each pass through SYNC_STAGES flops. Edge detection uses the synchronized value and one extra delay flop.
- **Registers:**
  - holding register `hold` and `fresh` flag;
  - TX shift register, RX shift register;
  - bit counter `cnt`, range 0..WIDTH;
  - FSM with states IDLE, SHIFT, DONE.
- **`tx_we` handling:** loads `hold <= tx_data` and sets `fresh = 1` in any state. The active TX shift register is never disturbed.
- **IDLE:**
  - On synchronized `cs` falling: TX shift <= `hold`; `miso` <= `hold[WIDTH-1]`; `miso_oeb` <= 0; `cnt` <= 0; go to SHIFT.
  - If `fresh == 0` at that point, pulse `tx_underrun` and send the previous `hold` unchanged.
  - `fresh` clears on frame start. A `tx_we` on the same cycle wins: `fresh` stays 1 for the next frame, and the TX shift register loads the old `hold`.
- **SHIFT:**
  - On synchronized `sclk` rising: RX shift <= {RX shift[WIDTH-2:0], `mosi_s`}; `cnt` <= `cnt` + 1.
  - When `cnt` reaches WIDTH: `rx_data` <= received word; pulse `rx_valid`; go to DONE.
  - On synchronized `sclk` falling with `cnt` < WIDTH: shift TX left; `miso` <= next bit.
  - On synchronized `cs` rising: pulse `frame_err`; `rx_data` unchanged; go to IDLE.
- **DONE:**
  - Further `sclk` rising edges: pulse `frame_err` once per frame (overrun). The bits are ignored and `miso` holds 0.
  - On `cs` rising: go to IDLE.
- **Returning to IDLE:** `miso_oeb` <= 1 and `miso` <= 0.
- **Simultaneous events:** `cs` rising on the same cycle as the WIDTH-th `sclk` rising is a completed frame. `rx_valid` pulses, `frame_err` does not.
- **Reset mid-frame:** abandons the frame immediately; no `rx_valid` and no `frame_err`.

## Timing
- **Reset values:** `miso` = 0, `miso_oeb` = 1, `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `tx_underrun` = 0, `busy` = 0; `hold` = 0, `fresh` = 0; FSM = IDLE.
- **Latency** (pin edge to registered effect) is SYNC_STAGES+1 `wb_clk_i` cycles for `cs` and `sclk` edges. This gives 3 cycles at the default.
- **`rx_valid`** asserts on the cycle the WIDTH-th synchronized rising edge is processed, and lasts exactly 1 cycle.
- **Master constraints:**
  - `sclk` high and low times are each at least SYNC_STAGES+2 `wb_clk_i` periods.
  - The `cs` fall to first `sclk` rise is at least SYNC_STAGES+2 periods.
  - The last `sclk` fall to `cs` rise is at least 1 `sclk` period.
  - Under these constraints `miso` is settled before every master sampling edge.
- **`mosi`** must be stable around `sclk` rising. Its synchronizer matches the `sclk` path depth, so the sample taken is the value present at the edge.

## Test plan
- **Basic frame:** `tx_we` with `tx_data`=16'hA5C3, then a 16-bit frame with `mosi`=16'h1234, `sclk` half-period 4 clks. Required: master reads 16'hA5C3 on `miso`; `rx_data`=16'h1234 with a single `rx_valid` pulse; `miso_oeb` low only while `cs` is low.
- **Abort:** `cs` rises after 9 bits. Required: `frame_err` pulses once; `rx_data` keeps its prior value; the next full frame with `mosi`=16'hFFFF gives `rx_data`=16'hFFFF.
- **Underrun:** two frames with no `tx_we` between them, after `hold`=16'h00FF. Required: second frame transmits 16'h00FF again and `tx_underrun` pulses once at its start.
- **Overrun:** 18 `sclk` pulses in one frame with `mosi`=16'h8001 followed by 2 extra bits. Required: `rx_data`=16'h8001, one `rx_valid`, one `frame_err`, `miso`=0 during the extra bits.
- **Write during frame:** `tx_we` with 16'h5555 midway through a frame sending 16'hAAAA. Required: current frame completes as 16'hAAAA; next frame sends 16'h5555 without `tx_underrun`.
- **Reset mid-frame:** assert `wb_rst_i` after bit 5. Required: all outputs go to reset values immediately, with no `rx_valid` or `frame_err`.
